alu_cmd_seq: RTL and testbench

//  Command-side initiator for the 4-bit combinational ALU port (a, b, f[4:0], v -> y[3:0]).
//  - Accepts one operation per valid/ready request.
//  - Drives the ALU ports one or two cycles per request.
//  - Two-word ops use v=0 then v=1.
//  - Assembles an 8-bit result and returns it on a valid/ready response channel.
//  - Sits between the control front end and the ALU instance.

---
 rtl/alu_cmd_seq.sv | 138 +++++++++++++
 tb/tb_alu_cmd_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// Request/response sequencer that drives a 4-bit combinational ALU for one or two
// cycles per op and returns an 8-bit {hi, lo} result. Optional macro: DIV0_CHECK_EN.
module alu_cmd_seq #(
  parameter logic [4:0] IDLE_F = 5'b11111
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [3:0] req_a_i,
  input  logic [3:0] req_b_i,
  input  logic [4:0] req_f_i,
  output logic [3:0] alu_a_o,
  output logic [3:0] alu_b_o,
  output logic [4:0] alu_f_o,
  output logic       alu_v_o,
  input  logic [3:0] alu_y_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o
);

  localparam logic [4:0] F_SHL = 5'b00000;
  localparam logic [4:0] F_ADD = 5'b00010;
  localparam logic [4:0] F_SUB = 5'b00011;
  localparam logic [4:0] F_MUL = 5'b00100;
  localparam logic [4:0] F_DIV = 5'b00110;
  localparam logic [4:0] F_AND = 5'b01000;
  localparam logic [4:0] F_OR  = 5'b01100;
  localparam logic [4:0] F_SHR = 5'b10000;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;

  state_t     state_q, state_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic [4:0] alu_f_q, alu_f_d;
  logic       alu_v_q, alu_v_d;
  logic [7:0] data_q, data_d;
  logic       err_q, err_d;
  logic       two_word, one_word, bad_op;

  function automatic logic is_two_word(input logic [4:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_MUL) || (f == F_DIV);
  endfunction

  assign two_word = is_two_word(req_f_i);
  assign one_word = (req_f_i == F_AND) || (req_f_i == F_OR) ||
                    (req_f_i == F_SHL) || (req_f_i == F_SHR);

  // Rejected ops never reach the ALU; they go straight to the response.
`ifdef DIV0_CHECK_EN
  assign bad_op = !(two_word || one_word) || ((req_f_i == F_DIV) && (req_b_i == 4'd0));
`else
  assign bad_op = !(two_word || one_word);
`endif

  always_comb begin
    state_d = state_q;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_f_d = alu_f_q;
    alu_v_d = alu_v_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          data_d = 8'h00;
          if (bad_op) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            alu_a_d = req_a_i;
            alu_b_d = req_b_i;
            alu_f_d = req_f_i;
            alu_v_d = 1'b0;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        data_d[3:0] = alu_y_i;
        if (is_two_word(alu_f_q)) begin
          alu_v_d = 1'b1;
          state_d = S_HI;
        end else begin
          state_d = S_RESP;
        end
      end
      S_HI: begin
        data_d[7:4] = alu_y_i;
        state_d     = S_RESP;
      end
      S_RESP: begin
        // ALU ports hold the last op until the result is taken.
        if (rsp_ready_i) begin
          alu_f_d = IDLE_F;
          alu_v_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      alu_a_q <= 4'd0;
      alu_b_q <= 4'd0;
      alu_f_q <= IDLE_F;
      alu_v_q <= 1'b0;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_f_q <= alu_f_d;
      alu_v_q <= alu_v_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_f_o     = alu_f_q;
  assign alu_v_o     = alu_v_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with a behavioural 4-bit ALU attached to its ports.
module tb_alu_cmd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready;
  logic [3:0] req_a, req_b;
  logic [4:0] req_f;
  logic [3:0] alu_a, alu_b, alu_y;
  logic [4:0] alu_f;
  logic       alu_v;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_cmd_seq dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_f_i(req_f),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_f_o(alu_f), .alu_v_o(alu_v),
    .alu_y_i(alu_y),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
  );

  // ALU model; divide by zero returns quotient 4'hF and remainder a.
  logic [7:0] wide;
  always_comb begin
    wide  = 8'h00;
    alu_y = 4'h0;
    case (alu_f)
      5'b00010: begin wide = {4'h0, alu_a} + {4'h0, alu_b}; alu_y = alu_v ? {3'b0, wide[4]} : wide[3:0]; end
      5'b00011: begin wide = {4'h0, alu_a} - {4'h0, alu_b}; alu_y = alu_v ? {3'b0, wide[4]} : wide[3:0]; end
      5'b00100: begin wide = {4'h0, alu_a} * {4'h0, alu_b}; alu_y = alu_v ? wide[7:4] : wide[3:0]; end
      5'b00110: begin
        if (alu_b == 4'd0) alu_y = alu_v ? alu_a : 4'hF;
        else               alu_y = alu_v ? (alu_a % alu_b) : (alu_a / alu_b);
      end
      5'b01000: alu_y = alu_a & alu_b;
      5'b01100: alu_y = alu_a | alu_b;
      5'b00000: alu_y = alu_a << 1;
      5'b10000: alu_y = alu_a >> 1;
      default:  alu_y = 4'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] f, input logic [7:0] exp_data,
                        input logic exp_err, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, ".req_ready"}, 16'(req_ready), 16'd1);
    req_valid = 1'b1; req_a = a; req_b = b; req_f = f;
    @(posedge clk); #1;
    req_valid = 1'b0; req_a = 4'h5; req_b = 4'hA; req_f = 5'b01010;
    if (exp_lat > 1) begin
      chk({tag, ".lo_f"}, 16'(alu_f), 16'(f));
      chk({tag, ".lo_v"}, 16'(alu_v), 16'd0);
    end else begin
      chk({tag, ".err_f"}, 16'(alu_f), 16'h1F);
    end
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 16'(lat), 16'(exp_lat));
    chk({tag, ".data"}, 16'(rsp_data), 16'(exp_data));
    chk({tag, ".err"}, 16'(rsp_err), 16'(exp_err));
    chk({tag, ".busy"}, 16'(req_ready), 16'd0);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk({tag, ".done_v"}, 16'(rsp_valid), 16'd0);
    chk({tag, ".done_f"}, 16'(alu_f), 16'h1F);
    chk({tag, ".done_av"}, 16'(alu_v), 16'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = 4'h0; req_b = 4'h0; req_f = 5'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 16'(req_ready), 16'd1);
    chk("rst.rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst.rsp_data",  16'(rsp_data),  16'd0);
    chk("rst.rsp_err",   16'(rsp_err),   16'd0);
    chk("rst.alu_abv",   {7'd0, alu_a, alu_b, alu_v}, 16'd0);
    chk("rst.alu_f",     16'(alu_f),     16'h1F);
    rst = 1'b0;

    run_op("add",  4'd14, 4'd6,  5'b00010, 8'h14, 1'b0, 3);
    run_op("sub",  4'd14, 4'd6,  5'b00011, 8'h08, 1'b0, 3);
    run_op("subb", 4'd6,  4'd14, 5'b00011, 8'h18, 1'b0, 3);
    run_op("mul",  4'd14, 4'd6,  5'b00100, 8'h54, 1'b0, 3);
    run_op("div",  4'd14, 4'd6,  5'b00110, 8'h22, 1'b0, 3);
    run_op("and",  4'd14, 4'd6,  5'b01000, 8'h06, 1'b0, 2);
    run_op("or",   4'd14, 4'd6,  5'b01100, 8'h0E, 1'b0, 2);
    run_op("shl",  4'd14, 4'd6,  5'b00000, 8'h0C, 1'b0, 2);
    run_op("shr",  4'd14, 4'd6,  5'b10000, 8'h07, 1'b0, 2);
    run_op("bad",  4'd14, 4'd6,  5'b11111, 8'h00, 1'b1, 1);
`ifdef DIV0_CHECK_EN
    run_op("div0", 4'd9,  4'd0,  5'b00110, 8'h00, 1'b1, 1);
`else
    run_op("div0", 4'd9,  4'd0,  5'b00110, 8'h9F, 1'b0, 3);
`endif

    // Backpressure: response held while new requests are offered and ignored.
    @(negedge clk);
    req_valid = 1'b1; req_a = 4'd14; req_b = 4'd6; req_f = 5'b00100;
    @(posedge clk); #1;
    req_a = 4'd3; req_b = 4'd3; req_f = 5'b00010;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 16'(rsp_valid), 16'd1);
      chk("bp.data",  16'(rsp_data),  16'h54);
      chk("bp.ready", 16'(req_ready), 16'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    chk("bp.done", 16'(rsp_valid), 16'd0);

    // Reset while in HI aborts the op.
    @(negedge clk);
    req_valid = 1'b1; req_a = 4'd14; req_b = 4'd6; req_f = 5'b00100;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("hi.alu_v", 16'(alu_v), 16'd1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rsthi.rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rsthi.req_ready", 16'(req_ready), 16'd1);
    chk("rsthi.alu_f",     16'(alu_f),     16'h1F);
    chk("rsthi.alu_v",     16'(alu_v),     16'd0);
    chk("rsthi.rsp_data",  16'(rsp_data),  16'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rsthi.idle", 16'(rsp_valid), 16'd0);

    run_op("post", 4'd9, 4'd4, 5'b00010, 8'h0D, 1'b0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
